miriscv_data_mem_responder: RTL



---
 rtl/miriscv_data_mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/miriscv_data_mem_responder.sv
// ---------------------------------------------------------------------------
// miriscv_data_mem_responder
//
// Slave end of the core data interface. Accepts one load/store at a time via
// a request/grant handshake, performs byte-enabled word writes or whole-word
// reads on an internal word-addressed array, and returns a one-cycle response
// strobe RESP_LATENCY cycles after the grant. The full aligned word is always
// returned. Byte/half extraction and sign extension are left to the core.
//
// Parameters
//   XLEN          data/address width (byte lanes are fixed at 4, so 32)
//   MEM_WORDS     array depth in words, power of two, at least 2
//   RESP_LATENCY  grant-to-rvalid distance in cycles, 1..15
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous active-high reset
//   data_req_i     in   request valid, held until granted
//   data_we_i      in   1 = store, 0 = load
//   data_be_i      in   store byte enables (ignored for loads)
//   data_addr_i    in   byte address; [1:0] and bits above the index ignored
//   data_wdata_i   in   lane-aligned store data
//   data_gnt_o     out  request accepted this cycle (combinational)
//   data_rvalid_o  out  one-cycle response strobe (loads and stores)
//   data_rdata_o   out  read word, 0 for store responses
// ---------------------------------------------------------------------------
module miriscv_data_mem_responder #(
  parameter int XLEN         = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int RESP_LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [XLEN-1:0] data_rdata_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  // Counter reload for the WAIT countdown. With a latency of 1 the WAIT
  // state is never entered, so the reload value is irrelevant there.
  localparam logic [3:0] WAIT_LOAD = (RESP_LATENCY > 1) ? 4'(RESP_LATENCY - 2) : 4'd0;
  localparam logic       LAT_ONE   = (RESP_LATENCY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_s;
  logic              rvalid_r;
  logic [XLEN-1:0]   rdata_r;
  logic              gnt_s;
  logic [IDX_W-1:0]  index_s;
  logic [XLEN-1:0]   mem_r [MEM_WORDS];
  logic              unused_addr_s;

  // Merge store data into the old word, lane by lane, under the byte enables.
  function automatic logic [XLEN-1:0] merge_lanes(
    input logic [XLEN-1:0] old_word,
    input logic [XLEN-1:0] new_word,
    input logic [3:0]      be
  );
    logic [XLEN-1:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return res;
  endfunction

  // Address bits outside the word index are intentionally ignored (wrap).
  assign unused_addr_s = ^{data_addr_i[XLEN-1:IDX_W+2], data_addr_i[1:0]};
  assign index_s       = data_addr_i[IDX_W+1:2];

  // Grant only when no request is waiting for its latency to expire. The RESP
  // cycle may accept the next request so back-to-back traffic is possible.
  assign gnt_s = data_req_i & ~rst_i & ((state_r == ST_IDLE) | (state_r == ST_RESP));

  assign data_gnt_o    = gnt_s;
  assign data_rvalid_o = rvalid_r;
  assign data_rdata_o  = rdata_r;

  // Next-state and countdown logic for the response sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (gnt_s) begin
          if (LAT_ONE) begin
            state_s = ST_RESP;
            cnt_s   = 4'd0;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
          cnt_s   = cnt_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
          cnt_s   = cnt_r;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, countdown and response-strobe registers. The strobe is registered
  // from the next-state decode so it is high exactly while the FSM is in RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      rvalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rvalid_r <= (state_s == ST_RESP);
    end
  end

  // Response data register: captured on the grant edge (old array contents
  // for loads, zero for stores) and held until the next grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_r <= '0;
    end else if (gnt_s) begin
      rdata_r <= data_we_i ? '0 : mem_r[index_s];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Storage array, deliberately not reset. A store commits on its own grant
  // edge, so a pending response being dropped by reset never undoes it.
  always_ff @(posedge clk_i) begin
    if (gnt_s && data_we_i) begin
      mem_r[index_s] <= merge_lanes(mem_r[index_s], data_wdata_i, data_be_i);
    end
  end

endmodule
